icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: IDX_W, default 4, index width; 2^IDX_W direct-mapped one-word entries; tag = addr[31:IDX_W+2].
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rdy  input  1  global enable; low freezes all state and outputs.
REQ-005 if_req  input  1  fetch request, held high with stable if_addr until if_valid.
REQ-006 if_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 clear  input  1  pipeline flush; cancels the current fetch response.
REQ-008 if_valid  output  1  one-cycle pulse, if_inst valid for the request.
REQ-009 if_inst  output  32  returned instruction word.
REQ-010 ins_fetch_sig  output  1  refill request to the memory controller.
REQ-011 ins_addr  output  32  refill base address, word-aligned.
REQ-012 ins_fetch_done  input  1  one-cycle refill-complete pulse.
REQ-013 ins_data  input  96  [31:0]=word@ins_addr, [63:32]=@+4, [95:64]=@+8.

Function
REQ-014 States: IDLE, WAIT_MEM, RESP; all transitions occur only on edges with rdy high.
REQ-015 IDLE, if_req high, clear low, valid[idx] and tag match: if_valid=1 and if_inst=entry on the next cycle; state remains IDLE.
REQ-016 IDLE, if_req high, clear low, miss: next cycle ins_fetch_sig=1, ins_addr={if_addr[31:2],2'b00}; state goes to WAIT_MEM and the miss address is latched.
REQ-017 WAIT_MEM: ins_fetch_sig and ins_addr held stable until ins_fetch_done is sampled high; ins_fetch_sig is low from the following cycle.
REQ-018 On the ins_fetch_done edge: the three words are written to the entries for addr, addr+4 and addr+8, with valid=1 and tag set; addresses wrap modulo 2^32; indices wrap modulo 2^IDX_W.
REQ-019 After that same edge, go to RESP: if_valid=1 and if_inst=ins_data[31:0] for one cycle, then return to IDLE.
REQ-020 If clear is high in WAIT_MEM, or coincides with ins_fetch_done, a drop flag is set: the fill is still written, RESP is skipped, and the block returns to IDLE with no if_valid.
REQ-021 If clear is high in IDLE, the lookup is suppressed: no if_valid and no refill that cycle.
REQ-022 If clear is high in RESP, if_valid is suppressed; the state still returns to IDLE.
REQ-023 A hit pulse is never followed in the next cycle by a second pulse for the same request; the requester drops or changes if_req after if_valid.
REQ-024 At most one refill is outstanding; if_req while in WAIT_MEM or RESP is ignored.
REQ-025 ins_fetch_done is ignored outside WAIT_MEM.
REQ-026 With rdy low, a pending ins_fetch_done is not lost: the memory controller is frozen by the same rdy.

Reset
REQ-027 rst_n low asynchronously: state=IDLE, all valid bits=0, drop flag=0, if_valid=0, if_inst=0, ins_fetch_sig=0, ins_addr=0.
REQ-028 Data and tag arrays are not reset.
REQ-029 Reset during WAIT_MEM abandons the refill; a later ins_fetch_done is ignored per REQ-025.

Configuration
REQ-030 Macro ICACHE_FILL_ALL_EN defined: a refill writes all three returned words (REQ-018).
REQ-031 ICACHE_FILL_ALL_EN undefined: only ins_data[31:0] is written; [95:32] is discarded; all other behaviour is identical.

Verification
REQ-032 Reset, then if_req addr 0x0000_0100 -> ins_fetch_sig=1, ins_addr=0x100; done with data {C,B,A} -> if_valid with if_inst=A one cycle after done.
REQ-033 Following REQ-032, if_req 0x104 then 0x108 -> each hits: if_valid next cycle with B, then C, no ins_fetch_sig; without ICACHE_FILL_ALL_EN each misses.
REQ-034 Conflict: fill 0x100, then request 0x140 (IDX_W=4, same index) -> miss and refill; a later 0x100 misses again.
REQ-035 Miss pending, clear pulsed before done -> no if_valid; a later if_req at the same address hits in 1 cycle.
REQ-036 Wrap: if_req 0xFFFF_FFFC -> refill; 0x0000_0000 and 0x0000_0004 then hit with words B and C.
REQ-037 rdy low for 3 cycles while done is pending -> no state change; the response appears after rdy returns high.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped single-word-line instruction cache with a three-word refill.
// Define ICACHE_FILL_ALL_EN to write all three refill words; otherwise only the first is kept.
module icache #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        clear,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        ins_fetch_sig,
  output logic [31:0] ins_addr,
  input  logic        ins_fetch_done,
  input  logic [95:0] ins_data
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, RESP} state_t;

  state_t            state;
  logic              drop;
  logic              if_valid_r;
  logic [DEPTH-1:0]  valid;
  logic [31:0]       data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              fill_en;
  logic [29:0]       fill_w0;

  assign req_idx = if_addr[IDX_W+1:2];
  assign req_tag = if_addr[31:IDX_W+2];
  assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign fill_en = rdy && (state == WAIT_MEM) && ins_fetch_done;
  assign fill_w0 = ins_addr[31:2];

  // A clear arriving while the refill response is on the bus withdraws it.
  assign if_valid = if_valid_r && !((state == RESP) && clear);

`ifdef ICACHE_FILL_ALL_EN
  // Word arithmetic wraps the byte address modulo 2^32 for free.
  logic [29:0] fill_w1;
  logic [29:0] fill_w2;
  logic        unused_bits;
  assign fill_w1     = fill_w0 + 30'd1;
  assign fill_w2     = fill_w0 + 30'd2;
  assign unused_bits = ^{if_addr[1:0], ins_addr[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{if_addr[1:0], ins_addr[1:0], ins_data[95:32]};
`endif

  // Data and tag arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_mem[fill_w0[IDX_W-1:0]] <= ins_data[31:0];
      tag_mem[fill_w0[IDX_W-1:0]]  <= fill_w0[29:IDX_W];
`ifdef ICACHE_FILL_ALL_EN
      data_mem[fill_w1[IDX_W-1:0]] <= ins_data[63:32];
      tag_mem[fill_w1[IDX_W-1:0]]  <= fill_w1[29:IDX_W];
      data_mem[fill_w2[IDX_W-1:0]] <= ins_data[95:64];
      tag_mem[fill_w2[IDX_W-1:0]]  <= fill_w2[29:IDX_W];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      drop          <= 1'b0;
      valid         <= '0;
      if_valid_r    <= 1'b0;
      if_inst       <= '0;
      ins_fetch_sig <= 1'b0;
      ins_addr      <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if_valid_r <= 1'b0;
          // Skipping lookup right after a hit pulse stops a held request from hitting twice.
          if (if_req && !clear && !if_valid_r) begin
            if (hit) begin
              if_valid_r <= 1'b1;
              if_inst    <= data_mem[req_idx];
            end else begin
              ins_fetch_sig <= 1'b1;
              ins_addr      <= {if_addr[31:2], 2'b00};
              state         <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (ins_fetch_done) begin
            ins_fetch_sig           <= 1'b0;
            valid[fill_w0[IDX_W-1:0]] <= 1'b1;
`ifdef ICACHE_FILL_ALL_EN
            valid[fill_w1[IDX_W-1:0]] <= 1'b1;
            valid[fill_w2[IDX_W-1:0]] <= 1'b1;
`endif
            if (drop || clear) begin
              drop  <= 1'b0;
              state <= IDLE;
            end else begin
              if_valid_r <= 1'b1;
              if_inst    <= ins_data[31:0];
              state      <= RESP;
            end
          end else if (clear) begin
            drop <= 1'b1;
          end
        end
        RESP: begin
          if_valid_r <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (IDX_W=4), covering both fill configurations.
module tb_icache;

`ifdef ICACHE_FILL_ALL_EN
  localparam bit FILL_ALL = 1'b1;
`else
  localparam bit FILL_ALL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        clear;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        ins_fetch_sig;
  logic [31:0] ins_addr;
  logic        ins_fetch_done;
  logic [95:0] ins_data;

  int compared   = 0;
  int mismatched = 0;

  icache #(.IDX_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rdy(rdy),
    .if_req(if_req),
    .if_addr(if_addr),
    .clear(clear),
    .if_valid(if_valid),
    .if_inst(if_inst),
    .ins_fetch_sig(ins_fetch_sig),
    .ins_addr(ins_addr),
    .ins_fetch_done(ins_fetch_done),
    .ins_data(ins_data)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One fetch: a hit must pulse next cycle; a miss must refill with 'fill' and return fill[31:0].
  task automatic apply_stimulus(input logic [31:0] addr, input bit exp_hit,
                                input logic [31:0] exp_word, input logic [95:0] fill,
                                input string name);
    if_req  = 1'b1;
    if_addr = addr;
    @(negedge clk);
    if (exp_hit) begin
      check_output({name, " hit valid"}, 32'(if_valid), 32'd1);
      check_output({name, " hit inst"}, if_inst, exp_word);
      check_output({name, " hit no refill"}, 32'(ins_fetch_sig), 32'd0);
      if_req = 1'b0;
      @(negedge clk);
      check_output({name, " hit pulse end"}, 32'(if_valid), 32'd0);
    end else begin
      check_output({name, " miss no valid"}, 32'(if_valid), 32'd0);
      check_output({name, " miss sig"}, 32'(ins_fetch_sig), 32'd1);
      check_output({name, " miss addr"}, ins_addr, {addr[31:2], 2'b00});
      @(negedge clk);
      check_output({name, " sig held"}, 32'(ins_fetch_sig), 32'd1);
      ins_fetch_done = 1'b1;
      ins_data       = fill;
      @(negedge clk);
      check_output({name, " resp valid"}, 32'(if_valid), 32'd1);
      check_output({name, " resp inst"}, if_inst, fill[31:0]);
      check_output({name, " sig dropped"}, 32'(ins_fetch_sig), 32'd0);
      ins_fetch_done = 1'b0;
      if_req         = 1'b0;
      @(negedge clk);
      check_output({name, " resp end"}, 32'(if_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; if_req = 1'b0; if_addr = '0; clear = 1'b0;
    ins_fetch_done = 1'b0; ins_data = '0;
    $display("[TB] start, FILL_ALL=%0d", FILL_ALL);
    @(negedge clk);
    @(negedge clk);
    check_output("rst if_valid", 32'(if_valid), 32'd0);
    check_output("rst if_inst", if_inst, 32'd0);
    check_output("rst sig", 32'(ins_fetch_sig), 32'd0);
    check_output("rst ins_addr", ins_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post-rst idle", 32'(if_valid), 32'd0);

    // Basic refill then neighbours from the same refill.
    apply_stimulus(32'h0000_0100, 1'b0, 32'h0, {32'hCCCC_0108, 32'hBBBB_0104, 32'hAAAA_0100}, "fill100");
    apply_stimulus(32'h0000_0104, FILL_ALL, 32'hBBBB_0104, {64'h0, 32'h1111_0104}, "req104");
    apply_stimulus(32'h0000_0108, FILL_ALL, 32'hCCCC_0108, {64'h0, 32'h1111_0108}, "req108");
    apply_stimulus(32'h0000_0100, 1'b1, 32'hAAAA_0100, 96'h0, "rehit100");

    // Conflict on index 0 evicts 0x100.
    apply_stimulus(32'h0000_0140, 1'b0, 32'h0, {32'h2222_0148, 32'h2222_0144, 32'h2222_0140}, "fill140");
    apply_stimulus(32'h0000_0100, 1'b0, 32'h0, {32'h3333_0108, 32'h3333_0104, 32'h3333_0100}, "evict100");
    apply_stimulus(32'h0000_0100, 1'b1, 32'h3333_0100, 96'h0, "hit100b");

    // Clear while the refill is outstanding: fill kept, response dropped.
    if_req = 1'b1; if_addr = 32'h0000_0200;
    @(negedge clk);
    check_output("clr200 sig", 32'(ins_fetch_sig), 32'd1);
    clear = 1'b1; if_req = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    ins_fetch_done = 1'b1; ins_data = {32'h4444_0208, 32'h4444_0204, 32'h4444_0200};
    @(negedge clk);
    check_output("clr200 no valid", 32'(if_valid), 32'd0);
    check_output("clr200 sig low", 32'(ins_fetch_sig), 32'd0);
    ins_fetch_done = 1'b0;
    @(negedge clk);
    check_output("clr200 still none", 32'(if_valid), 32'd0);
    apply_stimulus(32'h0000_0200, 1'b1, 32'h4444_0200, 96'h0, "hit200");

    // Clear coinciding with done.
    if_req = 1'b1; if_addr = 32'h0000_0700;
    @(negedge clk);
    check_output("clr700 sig", 32'(ins_fetch_sig), 32'd1);
    ins_fetch_done = 1'b1; clear = 1'b1; if_req = 1'b0;
    ins_data = {32'h5555_0708, 32'h5555_0704, 32'h5555_0700};
    @(negedge clk);
    check_output("clr700 no valid", 32'(if_valid), 32'd0);
    ins_fetch_done = 1'b0; clear = 1'b0;
    @(negedge clk);
    check_output("clr700 none after", 32'(if_valid), 32'd0);
    apply_stimulus(32'h0000_0700, 1'b1, 32'h5555_0700, 96'h0, "hit700");

    // Clear in idle suppresses both lookup and refill.
    if_req = 1'b1; if_addr = 32'h0000_0300; clear = 1'b1;
    @(negedge clk);
    check_output("clr idle no sig", 32'(ins_fetch_sig), 32'd0);
    check_output("clr idle no valid", 32'(if_valid), 32'd0);
    if_req = 1'b0; clear = 1'b0;
    @(negedge clk);

    // Address wrap across 0xFFFF_FFFC.
    apply_stimulus(32'hFFFF_FFFC, 1'b0, 32'h0, {32'hCCCC_0004, 32'hBBBB_0000, 32'hAAAA_FFFC}, "wrapfill");
    apply_stimulus(32'h0000_0000, FILL_ALL, 32'hBBBB_0000, {64'h0, 32'h6666_0000}, "wrap0");
    apply_stimulus(32'h0000_0004, FILL_ALL, 32'hCCCC_0004, {64'h0, 32'h6666_0004}, "wrap4");

    // rdy low for three cycles with done pending.
    if_req = 1'b1; if_addr = 32'h0000_0400;
    @(negedge clk);
    check_output("rdy400 sig", 32'(ins_fetch_sig), 32'd1);
    ins_fetch_done = 1'b1; ins_data = {32'h7777_0408, 32'h7777_0404, 32'h7777_0400}; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("rdy low sig held", 32'(ins_fetch_sig), 32'd1);
      check_output("rdy low no valid", 32'(if_valid), 32'd0);
    end
    rdy = 1'b1;
    @(negedge clk);
    check_output("rdy400 valid", 32'(if_valid), 32'd1);
    check_output("rdy400 inst", if_inst, 32'h7777_0400);
    ins_fetch_done = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check_output("rdy400 end", 32'(if_valid), 32'd0);

    // Clear during the response cycle withdraws if_valid.
    if_req = 1'b1; if_addr = 32'h0000_0500;
    @(negedge clk);
    ins_fetch_done = 1'b1; ins_data = {32'h8888_0508, 32'h8888_0504, 32'h8888_0500};
    @(negedge clk);
    check_output("resp500 valid", 32'(if_valid), 32'd1);
    ins_fetch_done = 1'b0; if_req = 1'b0; clear = 1'b1;
    #1;
    check_output("resp500 cleared", 32'(if_valid), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    check_output("resp500 after", 32'(if_valid), 32'd0);
    apply_stimulus(32'h0000_0500, 1'b1, 32'h8888_0500, 96'h0, "hit500");

    // Reset during a refill abandons it and invalidates the cache.
    if_req = 1'b1; if_addr = 32'h0000_0600;
    @(negedge clk);
    check_output("rst600 sig", 32'(ins_fetch_sig), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("rst600 sig cleared", 32'(ins_fetch_sig), 32'd0);
    check_output("rst600 addr cleared", ins_addr, 32'd0);
    rst_n = 1'b1; if_req = 1'b0;
    @(negedge clk);
    ins_fetch_done = 1'b1; ins_data = {32'h9999_0608, 32'h9999_0604, 32'h9999_0600};
    @(negedge clk);
    check_output("rst600 stray done", 32'(if_valid), 32'd0);
    ins_fetch_done = 1'b0;
    @(negedge clk);
    apply_stimulus(32'h0000_0500, 1'b0, 32'h0, {32'hDDDD_0508, 32'hDDDD_0504, 32'hDDDD_0500}, "postrst500");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
